led_hex_top: RTL and testbench



---
 rtl/led_hex_top.sv | 106 ++++++++++
 tb/tb_led_hex_top.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_hex_top.sv
// DE-series LED/HEX demo: switches mirrored on LEDR and shown in hex on HEX2..HEX0,
// plus an 8-bit pushbutton-driven register R shown on HEX4..HEX3.
module led_hex_top #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  logic       srst;
  logic [9:0] sw_s1_q, sw_s2_q;
  logic [2:0] key_s1_q, key_s2_q, key_s3_q;
  logic [2:0] hold_q, hold_d;
  logic [2:0] key_evt;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [7:0] r_q, r_d;
  logic [9:0] ledr_q;
  logic [6:0] hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

  assign srst = KEY[0];

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A key seen high at reset stays masked until the synchronized pipeline
  // (refilled after reset) shows it released; otherwise the s2 restart would fire it.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hold
      assign hold_d[gi]  = hold_q[gi] & ~(fill_q[SYNC_STAGES-1] & ~key_s2_q[gi]);
      assign key_evt[gi] = key_s2_q[gi] & ~key_s3_q[gi] & ~hold_q[gi];
    end
  endgenerate

  // Load beats increment, increment beats decrement.
  always_comb begin
    r_d = r_q;
    if (key_evt[0])      r_d = sw_s2_q[7:0];
    else if (key_evt[1]) r_d = r_q + 8'd1;
    else if (key_evt[2]) r_d = r_q - 8'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (srst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
      key_s3_q <= '0;
      hold_q   <= KEY[3:1];
      fill_q   <= '0;
      r_q      <= '0;
      ledr_q   <= '0;
      hex0_q   <= SEG_ZERO;
      hex1_q   <= SEG_ZERO;
      hex2_q   <= SEG_ZERO;
      hex3_q   <= SEG_ZERO;
      hex4_q   <= SEG_ZERO;
      hex5_q   <= SEG_BLANK;
    end else begin
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= KEY[3:1];
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
      hold_q   <= hold_d;
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      r_q      <= r_d;
      ledr_q   <= sw_s2_q;
      hex0_q   <= seg7(sw_s2_q[3:0]);
      hex1_q   <= seg7(sw_s2_q[7:4]);
      hex2_q   <= seg7({2'b00, sw_s2_q[9:8]});
      hex3_q   <= seg7(r_q[3:0]);
      hex4_q   <= seg7(r_q[7:4]);
      hex5_q   <= SEG_BLANK;
    end
  end

  assign LEDR = ledr_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;
  assign HEX4 = hex4_q;
  assign HEX5 = hex5_q;

endmodule

// File: tb/tb_led_hex_top.sv
// Directed, table-driven bench for led_hex_top: switch mirror, register R keys,
// priority, held keys, exact latencies and reset behaviour.
module tb_led_hex_top;

  logic       clk = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int checks = 0;
  int failures = 0;

  led_hex_top #(.SYNC_STAGES(2)) dut (
    .CLOCK_50(clk), .KEY(KEY), .SW(SW),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR(LEDR)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
  } sw_vec_t;

  typedef struct {
    logic [9:0] sw;
    logic [2:0] keys;   // {dec, inc, load}
    logic [7:0] r;
  } key_vec_t;

  sw_vec_t  sw_tab[3];
  key_vec_t key_tab[9];

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_r(input string name, input logic [7:0] r);
    check({name, "_hex3"}, {25'd0, HEX3}, {25'd0, seg(r[3:0])});
    check({name, "_hex4"}, {25'd0, HEX4}, {25'd0, seg(r[7:4])});
  endtask

  initial begin
    logic [9:0] prev_ledr;

    sw_tab[0] = '{10'h2A5, 10'h2A5, 7'h12, 7'h08, 7'h24};
    sw_tab[1] = '{10'h3FF, 10'h3FF, 7'h0E, 7'h0E, 7'h30};
    sw_tab[2] = '{10'h0C7, 10'h0C7, 7'h78, 7'h46, 7'h40};

    key_tab[0] = '{10'h03C, 3'b001, 8'h3C};
    key_tab[1] = '{10'h03C, 3'b010, 8'h3D};
    key_tab[2] = '{10'h0FF, 3'b001, 8'hFF};
    key_tab[3] = '{10'h0FF, 3'b010, 8'h00};
    key_tab[4] = '{10'h0FF, 3'b100, 8'hFF};
    key_tab[5] = '{10'h010, 3'b011, 8'h10};
    key_tab[6] = '{10'h010, 3'b110, 8'h11};
    key_tab[7] = '{10'h010, 3'b100, 8'h10};
    key_tab[8] = '{10'h055, 3'b001, 8'h55};

    // Reset
    KEY = 4'b0001;
    SW  = 10'h000;
    tick(2);
    KEY = 4'b0000;
    tick(1);
    check("rst_ledr", {22'd0, LEDR}, 32'h000);
    check("rst_hex0", {25'd0, HEX0}, 32'h40);
    check("rst_hex1", {25'd0, HEX1}, 32'h40);
    check("rst_hex2", {25'd0, HEX2}, 32'h40);
    check("rst_hex3", {25'd0, HEX3}, 32'h40);
    check("rst_hex4", {25'd0, HEX4}, 32'h40);
    check("rst_hex5", {25'd0, HEX5}, 32'h7F);
    $display("reset: ledr=%h hex4..0=%h %h %h %h %h hex5=%h", LEDR, HEX4, HEX3, HEX2, HEX1, HEX0, HEX5);

    // Switch mirror with exact 3-edge latency
    prev_ledr = 10'h000;
    for (int i = 0; i < 3; i++) begin
      SW = sw_tab[i].sw;
      tick(2);
      check("sw_edge2_ledr", {22'd0, LEDR}, {22'd0, prev_ledr});
      tick(1);
      check("sw_ledr", {22'd0, LEDR}, {22'd0, sw_tab[i].ledr});
      check("sw_hex0", {25'd0, HEX0}, {25'd0, sw_tab[i].h0});
      check("sw_hex1", {25'd0, HEX1}, {25'd0, sw_tab[i].h1});
      check("sw_hex2", {25'd0, HEX2}, {25'd0, sw_tab[i].h2});
      $display("sw vec %0d: sw=%h ledr=%h hex2..0=%h %h %h", i, SW, LEDR, HEX2, HEX1, HEX0);
      prev_ledr = sw_tab[i].ledr;
    end

    // Key actions on R, each key held 5 clocks
    for (int i = 0; i < 9; i++) begin
      SW  = key_tab[i].sw;
      KEY = 4'b0000;
      tick(3);
      KEY = {key_tab[i].keys, 1'b0};
      tick(5);
      KEY = 4'b0000;
      tick(3);
      check_r("key_r", key_tab[i].r);
      $display("key vec %0d: sw=%h keys=%b hex4/3=%h/%h", i, SW, key_tab[i].keys, HEX4, HEX3);
    end

    // Held increment for 20 clocks: one step only (55 -> 56)
    KEY = 4'b0100;
    tick(20);
    check_r("held_inc", 8'h56);
    KEY = 4'b0000;
    tick(3);
    $display("held inc: hex4/3=%h/%h", HEX4, HEX3);

    // Decrement press: display changes on the 4th edge, not the 3rd
    KEY = 4'b1000;
    tick(3);
    check_r("dec_edge3", 8'h56);
    tick(1);
    check_r("dec_edge4", 8'h55);
    KEY = 4'b0000;
    tick(3);
    $display("dec latency: hex4/3=%h/%h", HEX4, HEX3);

    // Reset on the edge where an increment would fire; key held through release
    KEY = 4'b0100;
    tick(2);
    KEY = 4'b0101;
    tick(1);
    KEY = 4'b0100;
    tick(1);
    check_r("midrst_r", 8'h00);
    tick(10);
    check_r("midrst_held", 8'h00);
    check("midrst_ledr", {22'd0, LEDR}, 32'h055);
    check("midrst_hex5", {25'd0, HEX5}, 32'h7F);
    $display("mid reset: hex4/3=%h/%h ledr=%h", HEX4, HEX3, LEDR);

    // Release and press again: the increment fires now
    KEY = 4'b0000;
    tick(3);
    KEY = 4'b0100;
    tick(5);
    KEY = 4'b0000;
    tick(2);
    check_r("repress_inc", 8'h01);
    $display("re-press inc: hex4/3=%h/%h", HEX4, HEX3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
